// File: rtl/snes_sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snes_sd_pkg
//  Purpose  : Shared types and constants for the backup-RAM sector server.
//  Revision : 1.0  initial release
// ============================================================================
package snes_sd_pkg;

    localparam int SECTOR_WORDS = 256;
    localparam int SECTOR_IDX_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_PUT  = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_CAP  = 3'd4,
        S_WR_REQ  = 3'd5,
        S_DONE    = 3'd6
    } bk_srv_state_t;

    // True when the sector number has bits above the usable LBA range.
    function automatic logic lba_out_of_range(input logic [31:0] lba, input int lba_w);
        return (lba >> lba_w) != 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bk_sector_server_if.sv
`default_nettype none
// ============================================================================
//  Module   : bk_sector_server_if
//  Purpose  : Sector handshake plus word-wide backing-memory port bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface bk_sector_server_if #(
    parameter int ADDR_W = 24
);
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [7:0]        sd_buff_addr;
    logic [15:0]       sd_buff_dout;
    logic              sd_buff_wr;
    logic [15:0]       sd_buff_din;
    logic              ro;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_din;
    logic [15:0]       mem_dout;
    logic              mem_ready;
    logic              busy;
    logic              err;

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, ro, mem_dout, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_din, busy, err
    );

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, ro, mem_dout, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_din, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/bk_sector_server.sv
`default_nettype none
// ============================================================================
//  Module   : bk_sector_server
//  Purpose  : Serves one 256-word sector per request between the requester's
//             sector buffer and a request/ready word memory.
//  Revision : 1.0  initial release
// ============================================================================
module bk_sector_server
    import snes_sd_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  wire logic         clk_sys,
    input  wire logic         RESET_N,
    bk_sector_server_if.slave bus
);
    localparam int LBA_W = ADDR_W - SECTOR_IDX_W;
    localparam logic [SECTOR_IDX_W-1:0] c_last_idx = SECTOR_IDX_W'(SECTOR_WORDS - 1);
    localparam logic [SECTOR_IDX_W-1:0] c_idx_one  = SECTOR_IDX_W'(1);

    bk_srv_state_t           r_state;
    bk_srv_state_t           w_state_nxt;
    logic [LBA_W-1:0]        r_lba;
    logic [SECTOR_IDX_W-1:0] r_idx;
    logic                    r_err;
    logic                    r_skip_wr;
    logic                    r_ack;
    logic                    r_buff_wr;
    logic [7:0]              r_buff_addr;
    logic [15:0]             r_buff_dout;
    logic [15:0]             r_mem_din;
    logic                    w_accept;
    logic                    w_rd_done;
    logic                    w_word_done;
    logic                    w_last;

    assign w_last = (r_idx == c_last_idx);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_done   = 1'b0;
        w_word_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.sd_rd || bus.sd_wr) begin
                    w_accept    = 1'b1;
                    w_state_nxt = bus.sd_rd ? S_RD_REQ : S_WR_ADDR;
                end
            end
            // Out-of-range reads complete without touching memory.
            S_RD_REQ: begin
                if (r_err || bus.mem_ready) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = S_RD_PUT;
                end
            end
            S_RD_PUT:  w_word_done = 1'b1;
            S_WR_ADDR: w_state_nxt = S_WR_CAP;
            S_WR_CAP: begin
                if (r_skip_wr) w_word_done = 1'b1;
                else           w_state_nxt = S_WR_REQ;
            end
            S_WR_REQ:  w_word_done = bus.mem_ready;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_word_done) begin
            if (w_last)                  w_state_nxt = S_DONE;
            else if (r_state == S_RD_PUT) w_state_nxt = S_RD_REQ;
            else                         w_state_nxt = S_WR_ADDR;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_lba       <= '0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_skip_wr   <= 1'b0;
            r_ack       <= 1'b0;
            r_buff_wr   <= 1'b0;
            r_buff_addr <= '0;
            r_buff_dout <= '0;
            r_mem_din   <= '0;
        end else begin
            r_buff_wr <= 1'b0;
            if (w_accept) begin
                r_lba       <= bus.sd_lba[LBA_W-1:0];
                r_idx       <= '0;
                r_ack       <= 1'b1;
                r_err       <= lba_out_of_range(bus.sd_lba, LBA_W);
                r_skip_wr   <= lba_out_of_range(bus.sd_lba, LBA_W) || bus.ro;
                r_buff_addr <= '0;
            end
            if (w_rd_done) begin
                r_buff_dout <= r_err ? 16'h0000 : bus.mem_dout;
                r_buff_addr <= r_idx;
                r_buff_wr   <= 1'b1;
            end
            if (r_state == S_WR_CAP) r_mem_din <= bus.sd_buff_din;
            // Write path presents the next word's buffer address one cycle
            // ahead so the registered buffer RAM has its data ready in WR_CAP.
            if (w_word_done) begin
                if (w_last) begin
                    r_ack <= 1'b0;
                end else begin
                    r_idx <= r_idx + c_idx_one;
                    if (r_state != S_RD_PUT) r_buff_addr <= r_idx + c_idx_one;
                end
            end
        end
    end

    assign bus.sd_ack       = r_ack;
    assign bus.sd_buff_addr = r_buff_addr;
    assign bus.sd_buff_dout = r_buff_dout;
    assign bus.sd_buff_wr   = r_buff_wr;
    assign bus.mem_addr     = {r_lba, r_idx};
    assign bus.mem_rd       = (r_state == S_RD_REQ) && !r_err;
    assign bus.mem_wr       = (r_state == S_WR_REQ);
    assign bus.mem_din      = r_mem_din;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bk_sector_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bk_sector_server
//  Purpose  : Directed and randomized sector transfers against a sector-level
//             reference of the backing memory and requester buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bk_sector_server;
    localparam int ADDR_W = 24;

    logic clk_sys;
    logic RESET_N;

    bk_sector_server_if #(.ADDR_W(ADDR_W)) bus ();

    bk_sector_server #(.ADDR_W(ADDR_W)) dut (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0]       mem     [int];
    logic [15:0]       ref_mem [int];
    logic [15:0]       buf_src [256];
    logic [23:0]       rd_log  [$];
    logic [39:0]       wr_log  [$];
    logic [7:0]        din_addr_q = 8'd0;
    int                lat_max    = 0;
    int                mem_cnt    = -1;
    int                mem_act    = 0;
    int                stab_err   = 0;
    logic [39:0]       mem_hold   = 40'd0;
    int                low_run    = 0;
    int                last_gap   = 0;

    function automatic logic [15:0] mem_val(input int a);
        return mem.exists(a) ? mem[a] : a[15:0];
    endfunction

    function automatic logic [15:0] ref_val(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : a[15:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Backing memory: random ready latency, checks address/data hold.
    always @(negedge clk_sys) begin
        bus.mem_ready = 1'b0;
        bus.mem_dout  = 16'($urandom);
        if (!RESET_N) begin
            mem_cnt = -1;
        end else if (bus.mem_rd || bus.mem_wr) begin
            mem_act++;
            if (mem_cnt < 0) begin
                mem_cnt  = int'($urandom_range(lat_max, 0));
                mem_hold = {bus.mem_addr, bus.mem_din};
            end else if (mem_hold !== {bus.mem_addr, bus.mem_din}) begin
                stab_err++;
            end
            if (mem_cnt == 0) begin
                bus.mem_ready = 1'b1;
                mem_cnt       = -1;
                if (bus.mem_rd) begin
                    bus.mem_dout = mem_val(int'(bus.mem_addr));
                end else begin
                    mem[int'(bus.mem_addr)] = bus.mem_din;
                    wr_log.push_back({bus.mem_addr, bus.mem_din});
                end
            end else begin
                mem_cnt--;
            end
        end
    end

    // Requester buffer: registered RAM read port plus write-strobe capture.
    always @(negedge clk_sys) begin
        bus.sd_buff_din = buf_src[din_addr_q];
        din_addr_q      = bus.sd_buff_addr;
        if (bus.sd_buff_wr) rd_log.push_back({bus.sd_buff_addr, bus.sd_buff_dout});
        if (!bus.sd_ack) begin
            low_run++;
        end else if (low_run > 0) begin
            last_gap = low_run;
            low_run  = 0;
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] lba,
                          input bit ro_in, input int lat, output int gap);
        logic [23:0] exp_rd [$];
        logic [39:0] exp_wr [$];
        bit oor, is_rd, skip, rose, done;
        int cycles, ack_hi, first_ack, per_word, n, bad, a;
        is_rd = rd;
        oor   = (lba >= (32'd1 << (ADDR_W - 8)));
        skip  = !is_rd && (oor || ro_in);
        for (int i = 0; i < 256; i++) begin
            a = int'(lba % 32'd65536) * 256 + i;
            if (is_rd) exp_rd.push_back({8'(i), oor ? 16'h0000 : ref_val(a)});
            else if (!skip) begin
                exp_wr.push_back({24'(a), buf_src[i]});
                ref_mem[a] = buf_src[i];
            end
        end
        per_word = (is_rd || skip) ? 2 : 3;

        rd_log.delete();
        wr_log.delete();
        mem_act    = 0;
        lat_max    = lat;
        bus.ro     = ro_in;
        bus.sd_lba = lba;
        bus.sd_rd  = rd;
        bus.sd_wr  = wr;
        cycles = 0; ack_hi = 0; first_ack = 0; rose = 0; done = 0;
        while (cycles < 6000 && !done) begin
            @(posedge clk_sys);
            #1;
            cycles++;
            if (bus.sd_ack) begin
                ack_hi++;
                if (!rose) begin
                    rose      = 1;
                    first_ack = cycles;
                    bus.sd_rd = 1'b0;
                    bus.sd_wr = 1'b0;
                end
            end
            done = rose && !bus.busy;
        end
        bus.sd_rd = 1'b0;
        bus.sd_wr = 1'b0;

        chk("complete", 64'(done), 64'd1);
        chk("ack_rise", 64'(first_ack), 64'd1);
        chk("ack_low_end", 64'(bus.sd_ack), 64'd0);
        chk("err", 64'(bus.err), 64'(oor));
        if (lat == 0) begin
            chk("ack_high_cycles", 64'(ack_hi), 64'(256 * per_word));
            chk("req_to_idle", 64'(cycles), 64'(256 * per_word + 2));
        end
        if (oor || skip) chk("no_mem_activity", 64'(mem_act), 64'd0);

        chk("rd_count", 64'(rd_log.size()), 64'(exp_rd.size()));
        n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
        bad = 0;
        for (int i = 0; i < n; i++) if (rd_log[i] !== exp_rd[i]) begin bad = i; break; end
        if (n > 0) chk("rd_addr_data", 64'(rd_log[bad]), 64'(exp_rd[bad]));

        chk("wr_count", 64'(wr_log.size()), 64'(exp_wr.size()));
        n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        bad = 0;
        for (int i = 0; i < n; i++) if (wr_log[i] !== exp_wr[i]) begin bad = i; break; end
        if (n > 0) chk("wr_addr_data", 64'(wr_log[bad]), 64'(exp_wr[bad]));

        @(negedge clk_sys);
        gap = last_gap;
    endtask

    initial begin
        int  gap;
        bit  rnd_rd;
        logic [31:0] rnd_lba;
        RESET_N      = 1'b0;
        bus.sd_lba   = 32'd0;
        bus.sd_rd    = 1'b0;
        bus.sd_wr    = 1'b0;
        bus.ro       = 1'b0;
        for (int i = 0; i < 256; i++) buf_src[i] = 16'd0;
        repeat (3) @(negedge clk_sys);
        chk("rst_ack_busy_err", 64'({bus.sd_ack, bus.busy, bus.err}), 64'd0);
        chk("rst_strobes", 64'({bus.sd_buff_wr, bus.mem_rd, bus.mem_wr}), 64'd0);
        chk("rst_buff", 64'({bus.sd_buff_addr, bus.sd_buff_dout}), 64'd0);
        chk("rst_mem", 64'({bus.mem_addr, bus.mem_din}), 64'd0);
        RESET_N = 1'b1;
        @(posedge clk_sys);
        #1;

        // Zero-wait read of LBA 3 from the identity-filled memory.
        do_req(1, 0, 32'd3, 0, 0, gap);

        // Zero-wait write of LBA 1 with inverted-index buffer, then read back.
        for (int i = 0; i < 256; i++) buf_src[i] = ~16'(i);
        do_req(0, 1, 32'd1, 0, 0, gap);
        do_req(1, 0, 32'd1, 0, 7, gap);

        // Random direction, sector, data and memory latency.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 256; i++) buf_src[i] = 16'($urandom);
            rnd_rd  = 1'($urandom_range(1, 0));
            rnd_lba = 32'($urandom_range(15, 0));
            do_req(rnd_rd, !rnd_rd, rnd_lba, 0, int'($urandom_range(7, 1)), gap);
        end
        chk("mem_hold_stable", 64'(stab_err), 64'd0);

        // Back-to-back reads: each new request raised as soon as ack falls.
        do_req(1, 0, 32'd0, 0, 0, gap);
        for (int l = 1; l < 4; l++) begin
            do_req(1, 0, 32'(l), 0, 0, gap);
            chk("ack_low_gap", 64'(gap >= 2), 64'd1);
        end

        // Boundary cases.
        do_req(1, 0, 32'h0001_0000, 0, 0, gap);
        do_req(0, 1, 32'h0001_0000, 0, 0, gap);
        do_req(0, 1, 32'd2, 1, 0, gap);
        do_req(1, 1, 32'd7, 0, 0, gap);

        // Reset in the middle of a read at word 100.
        lat_max    = 0;
        rd_log.delete();
        bus.sd_lba = 32'd5;
        bus.sd_rd  = 1'b1;
        for (int c = 0; c < 2000 && rd_log.size() < 100; c++) begin
            @(posedge clk_sys);
            #1;
            if (bus.sd_ack) bus.sd_rd = 1'b0;
        end
        bus.sd_rd = 1'b0;
        chk("mid_words", 64'(rd_log.size()), 64'd100);
        chk("mid_ack_mem_rd", 64'({bus.sd_ack, bus.mem_rd}), 64'b11);
        RESET_N = 1'b0;
        #1;
        chk("rst_async_ack_mem_rd", 64'({bus.sd_ack, bus.mem_rd}), 64'd0);
        chk("rst_async_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk_sys);
        RESET_N = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("post_rst_idle", 64'({bus.busy, bus.sd_ack}), 64'd0);
        do_req(1, 0, 32'd6, 0, 3, gap);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
